// File: rtl/mem_port_arbiter_if.sv
// Bundle between the three memory requesters, the arbiter and the memory block.
// The master modport is the requester/memory side; the arbiter takes the slave modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [2:0]        req;
  logic [2:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] wdata2;
  logic [2:0]        gnt;
  logic [2:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
    input  gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
    output gnt, done, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port memory between fetch, load/store
// and display readers; one access in flight, fixed MEM_LAT read latency.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        ptr;
  logic [1:0]        win;
  logic [1:0]        cnt;
  logic [1:0]        cand1;
  logic [1:0]        cand2;
  logic [1:0]        pick;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_sel;
  logic [DATA_W-1:0] rdata_q;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Search order ptr+1, ptr+2, ptr; the last candidate is taken only when it is the sole requester.
  assign cand1 = inc3(ptr);
  assign cand2 = inc3(cand1);
  assign pick  = bus.req[cand1] ? cand1 : (bus.req[cand2] ? cand2 : ptr);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    addr_sel  = bus.addr0;
    wdata_sel = bus.wdata0;
    case (pick)
      2'd1: begin
        addr_sel  = bus.addr1;
        wdata_sel = bus.wdata1;
      end
      2'd2: begin
        addr_sel  = bus.addr2;
        wdata_sel = bus.wdata2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.gnt     = 3'b000;
    bus.done    = 3'b000;
    bus.mem_en  = 1'b0;
    bus.mem_we  = 1'b0;
    case (state)
      IDLE: if (|bus.req) state_nxt = ISSUE;
      ISSUE: begin
        bus.gnt    = 3'b001 << win;
        bus.mem_en = 1'b1;
        bus.mem_we = we_q;
        state_nxt  = WAIT;
      end
      WAIT: if (cnt == 2'd0) state_nxt = DONE;
      DONE: begin
        bus.done  = 3'b001 << win;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= 2'd2;
      win     <= 2'd0;
      cnt     <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          win     <= pick;
          ptr     <= pick;
          we_q    <= bus.we[pick];
          addr_q  <= addr_sel;
          wdata_q <= wdata_sel;
        end
        ISSUE: cnt <= LAT_INIT;
        WAIT: begin
          if (cnt == 2'd0) begin
            if (!we_q) rdata_q <= bus.mem_rdata;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address and write data stay on the latched values outside ISSUE.
  assign bus.busy      = (state != IDLE);
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (MEM_LAT 1 and 4), each with its own latency-accurate memory, checked every
// cycle against a transaction-level model plus directed literal expectations.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [2:0]    req_d   [2];
  logic [2:0]    we_d    [2];
  logic [AW-1:0] addr_d  [2][3];
  logic [DW-1:0] wdata_d [2][3];

  logic [2:0]    gnt_o    [2];
  logic [2:0]    done_o   [2];
  logic [DW-1:0] rdata_o  [2];
  logic          busy_o   [2];
  logic          en_o     [2];
  logic          mwe_o    [2];
  logic [AW-1:0] maddr_o  [2];
  logic [DW-1:0] mwdata_o [2];

  logic [DW-1:0] ram  [2][1024];
  logic [DW-1:0] pipe [2][4];

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  assign bus_a.req = req_d[0];      assign bus_b.req = req_d[1];
  assign bus_a.we  = we_d[0];       assign bus_b.we  = we_d[1];
  assign bus_a.addr0 = addr_d[0][0]; assign bus_b.addr0 = addr_d[1][0];
  assign bus_a.addr1 = addr_d[0][1]; assign bus_b.addr1 = addr_d[1][1];
  assign bus_a.addr2 = addr_d[0][2]; assign bus_b.addr2 = addr_d[1][2];
  assign bus_a.wdata0 = wdata_d[0][0]; assign bus_b.wdata0 = wdata_d[1][0];
  assign bus_a.wdata1 = wdata_d[0][1]; assign bus_b.wdata1 = wdata_d[1][1];
  assign bus_a.wdata2 = wdata_d[0][2]; assign bus_b.wdata2 = wdata_d[1][2];
  assign bus_a.mem_rdata = pipe[0][0];
  assign bus_b.mem_rdata = pipe[1][3];

  assign gnt_o[0] = bus_a.gnt;           assign gnt_o[1] = bus_b.gnt;
  assign done_o[0] = bus_a.done;         assign done_o[1] = bus_b.done;
  assign rdata_o[0] = bus_a.rdata;       assign rdata_o[1] = bus_b.rdata;
  assign busy_o[0] = bus_a.busy;         assign busy_o[1] = bus_b.busy;
  assign en_o[0] = bus_a.mem_en;         assign en_o[1] = bus_b.mem_en;
  assign mwe_o[0] = bus_a.mem_we;        assign mwe_o[1] = bus_b.mem_we;
  assign maddr_o[0] = bus_a.mem_addr;    assign maddr_o[1] = bus_b.mem_addr;
  assign mwdata_o[0] = bus_a.mem_wdata;  assign mwdata_o[1] = bus_b.mem_wdata;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 4;
  endfunction

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 16) return 16'hBEEF;
    return DW'(a * 257) ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory block: samples mem_en at the edge, read data appears MEM_LAT edges later, garbage otherwise.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        for (int a = 0; a < 1024; a++) ram[g][a] <= init_val(a);
      end else if (en_o[g] && mwe_o[g]) begin
        ram[g][maddr_o[g][9:0]] <= mwdata_o[g];
      end
      pipe[g][0] <= (en_o[g] && !mwe_o[g]) ? ram[g][maddr_o[g][9:0]] : 16'hDEAD;
      for (int k = 1; k < 4; k++) pipe[g][k] <= pipe[g][k-1];
    end
  end

  // Transaction model: k counts cycles since the selecting IDLE cycle.
  bit            m_act   [2];
  int            m_k     [2];
  int            m_ptr   [2];
  int            m_win   [2];
  bit            m_we    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_rdata [2];
  logic [DW-1:0] ref_mem [2][1024];

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      m_act[g] = 1'b0; m_k[g] = 0; m_ptr[g] = 2; m_win[g] = 0; m_we[g] = 1'b0;
      m_addr[g] = '0; m_wdata[g] = '0; m_rdata[g] = '0;
      for (int a = 0; a < 1024; a++) ref_mem[g][a] = init_val(a);
    end
  endtask

  always @(negedge clk) begin
    if (reset) model_reset();
    for (int g = 0; g < 2; g++) begin
      logic [2:0] e_gnt, e_done;
      logic       e_en, e_we;
      string      tag;
      int         l;
      bit         found;
      l      = lat_of(g);
      tag    = $sformatf("L%0d", l);
      e_en   = m_act[g] && (m_k[g] == 1);
      e_we   = e_en && m_we[g];
      e_gnt  = e_en ? 3'(1 << m_win[g]) : 3'b000;
      e_done = (m_act[g] && m_k[g] == l + 2) ? 3'(1 << m_win[g]) : 3'b000;
      if (m_act[g] && m_k[g] == l + 2 && !m_we[g]) m_rdata[g] = ref_mem[g][m_addr[g][9:0]];
      check({tag, " gnt"},       32'(gnt_o[g]),    32'(e_gnt));
      check({tag, " done"},      32'(done_o[g]),   32'(e_done));
      check({tag, " mem_en"},    32'(en_o[g]),     32'(e_en));
      check({tag, " mem_we"},    32'(mwe_o[g]),    32'(e_we));
      check({tag, " busy"},      32'(busy_o[g]),   32'(m_act[g]));
      check({tag, " mem_addr"},  32'(maddr_o[g]),  32'(m_addr[g]));
      check({tag, " mem_wdata"}, 32'(mwdata_o[g]), 32'(m_wdata[g]));
      check({tag, " rdata"},     32'(rdata_o[g]),  32'(m_rdata[g]));
      if (!reset) begin
        if (m_act[g]) begin
          if (m_k[g] == l + 2) m_act[g] = 1'b0;
          else m_k[g]++;
        end else if (req_d[g] != 3'b000) begin
          found = 1'b0;
          for (int j = 1; j <= 3; j++) begin
            if (!found && req_d[g][(m_ptr[g] + j) % 3]) begin
              m_win[g] = (m_ptr[g] + j) % 3;
              found = 1'b1;
            end
          end
          m_ptr[g]   = m_win[g];
          m_we[g]    = we_d[g][m_win[g]];
          m_addr[g]  = addr_d[g][m_win[g]];
          m_wdata[g] = wdata_d[g][m_win[g]];
          if (m_we[g]) ref_mem[g][m_addr[g][9:0]] = m_wdata[g];
          m_act[g] = 1'b1;
          m_k[g]   = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int g = 0; g < 2; g++) begin
      req_d[g] = 3'b000;
      we_d[g]  = 3'b000;
      for (int p = 0; p < 3; p++) begin
        addr_d[g][p]  = '0;
        wdata_d[g][p] = '0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int g, input int p, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    we_d[g][p]    = w;
    addr_d[g][p]  = a;
    wdata_d[g][p] = d;
    req_d[g][p]   = 1'b1;
  endtask

  task automatic wait_done(input int g, input int p, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (done_o[g][p]) seen = 1'b1;
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    req_d[g][p] = 1'b0;
  endtask

  int            cyc_a[$], cyc_b[$];
  logic [2:0]    val_a[$], val_b[$];
  bit            pending [2][3];
  bit            drained;

  initial begin
    clear_reqs();
    reset = 1'b1;
    repeat (3) tick();
    check("reset gnt",      32'(gnt_o[0]),   32'd0);
    check("reset busy",     32'(busy_o[1]),  32'd0);
    check("reset rdata",    32'(rdata_o[0]), 32'd0);
    check("reset mem_addr", 32'(maddr_o[1]), 32'd0);
    reset = 1'b0;

    // Single read, MEM_LAT=1: memory holds 0xBEEF at 0x0010.
    set_req(0, 0, 1'b0, 16'h0010, 16'h0000);
    tick();
    check("read gnt T+1",  32'(gnt_o[0]),   32'b001);
    check("read en T+1",   32'(en_o[0]),    32'd1);
    check("read addr T+1", 32'(maddr_o[0]), 32'h0010);
    tick();
    check("read en T+2",   32'(en_o[0]),    32'd0);
    tick();
    check("read done T+3", 32'(done_o[0]),  32'b001);
    check("read rdata",    32'(rdata_o[0]), 32'hBEEF);
    req_d[0] = 3'b000;

    // Port 1 writes 0x1234 to 0x0100, then reads it back.
    tick();
    set_req(0, 1, 1'b1, 16'h0100, 16'h1234);
    tick();
    check("write gnt",     32'(gnt_o[0]),  32'b010);
    check("write mem_we",  32'(mwe_o[0]),  32'd1);
    tick();
    check("write mem_we T+2", 32'(mwe_o[0]), 32'd0);
    tick();
    check("write done",    32'(done_o[0]),  32'b010);
    check("write rdata kept", 32'(rdata_o[0]), 32'hBEEF);
    req_d[0] = 3'b000;
    tick();
    set_req(0, 1, 1'b0, 16'h0100, 16'h0000);
    repeat (3) tick();
    check("readback done",  32'(done_o[0]),  32'b010);
    check("readback rdata", 32'(rdata_o[0]), 32'h1234);
    req_d[0] = 3'b000;

    // Contention: all three ports read continuously from reset.
    do_reset();
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < 3; p++) set_req(g, p, 1'b0, 16'(16'h20 + p), 16'h0000);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (gnt_o[0] != 3'b000) begin cyc_a.push_back(c); val_a.push_back(gnt_o[0]); end
      if (gnt_o[1] != 3'b000) begin cyc_b.push_back(c); val_b.push_back(gnt_o[1]); end
    end
    check("rr L1 grants", 32'(cyc_a.size() >= 4), 32'd1);
    check("rr L4 grants", 32'(cyc_b.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < cyc_a.size() && k < cyc_b.size(); k++) begin
      logic [2:0] exp_g;
      exp_g = (k == 3) ? 3'b001 : 3'(1 << k);
      check($sformatf("rr L1 order %0d", k), 32'(val_a[k]), 32'(exp_g));
      check($sformatf("rr L4 order %0d", k), 32'(val_b[k]), 32'(exp_g));
      if (k > 0) begin
        check($sformatf("rr L1 spacing %0d", k), 32'(cyc_a[k] - cyc_a[k-1]), 32'd4);
        check($sformatf("rr L4 spacing %0d", k), 32'(cyc_b[k] - cyc_b[k-1]), 32'd7);
      end
    end

    // Round-robin skip: after port 0 is served, req=101 goes to port 2 then port 0.
    do_reset();
    set_req(0, 0, 1'b0, 16'h0003, 16'h0000);
    wait_done(0, 0, "skip first");
    tick();
    set_req(0, 0, 1'b0, 16'h0004, 16'h0000);
    set_req(0, 2, 1'b0, 16'h0005, 16'h0000);
    tick();
    check("skip gnt port2", 32'(gnt_o[0]), 32'b100);
    repeat (2) tick();
    req_d[0][2] = 1'b0;
    repeat (2) tick();
    check("skip gnt port0", 32'(gnt_o[0]), 32'b001);
    wait_done(0, 0, "skip second");

    // Request dropped the cycle after selection still completes.
    tick();
    set_req(0, 2, 1'b0, 16'h0006, 16'h0000);
    tick();
    check("drop gnt", 32'(gnt_o[0]), 32'b100);
    req_d[0][2] = 1'b0;
    repeat (2) tick();
    check("drop done", 32'(done_o[0]), 32'b100);
    tick();
    check("drop idle busy", 32'(busy_o[0]), 32'd0);

    // Asynchronous reset in WAIT with MEM_LAT=4, then req=110 picks port 1.
    set_req(1, 0, 1'b0, 16'h0007, 16'h0000);
    repeat (3) tick();
    check("pre-reset busy", 32'(busy_o[1]), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async busy",  32'(busy_o[1]),  32'd0);
    check("async done",  32'(done_o[1]),  32'd0);
    check("async en",    32'(en_o[1]),    32'd0);
    check("async addr",  32'(maddr_o[1]), 32'd0);
    check("async rdata", 32'(rdata_o[1]), 32'd0);
    clear_reqs();
    repeat (2) tick();
    set_req(1, 1, 1'b0, 16'h0008, 16'h0000);
    set_req(1, 2, 1'b0, 16'h0009, 16'h0000);
    reset = 1'b0;
    tick();
    check("post-reset winner", 32'(gnt_o[1]), 32'b010);
    wait_done(1, 1, "post-reset port1");
    wait_done(1, 2, "post-reset port2");

    // Random traffic on both instances, requesters obeying the hold-until-done rule.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        for (int p = 0; p < 3; p++) begin
          if (pending[g][p] && done_o[g][p]) begin
            pending[g][p] = 1'b0;
            req_d[g][p]   = 1'b0;
            if ($urandom_range(1, 0) == 1) pending[g][p] = 1'b1;
          end else if (!pending[g][p] && $urandom_range(4, 0) == 0) begin
            pending[g][p] = 1'b1;
          end
          if (pending[g][p] && !req_d[g][p])
            set_req(g, p, ($urandom_range(2, 0) == 0), 16'($urandom_range(31, 0)), 16'($urandom));
        end
      end
    end
    drained = 1'b0;
    for (int n = 0; n < 200 && !drained; n++) begin
      tick();
      drained = 1'b1;
      for (int g = 0; g < 2; g++) begin
        for (int p = 0; p < 3; p++) begin
          if (pending[g][p] && done_o[g][p]) begin
            pending[g][p] = 1'b0;
            req_d[g][p]   = 1'b0;
          end
          if (pending[g][p]) drained = 1'b0;
        end
        if (busy_o[g]) drained = 1'b0;
      end
    end
    check("random drain", 32'(drained), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
